icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache.
- Sits directly downstream of the datapath's icache port (imemREN/imemaddr in, ihit/imemload out).
- Upstream of the memory controller instruction channel (iREN/iaddr out, iload/iwait in).
- Fills one word per miss through a registered miss FSM; the datapath stalls until ihit is asserted.

Parameters:
- SETS, 16, number of frames; power of two, 2 to 256.
- IDX_W, $clog2(SETS), index width (derived; do not override).
- TAG_W, 30-IDX_W, tag width (derived).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  synchronous active-low reset; sampled on CLK rising edge.
- imemREN  in  1  datapath instruction read request.
- imemaddr  in  32  datapath instruction byte address; bits [1:0] ignored.
- ihit  out  1  requested word valid on imemload this cycle.
- imemload  out  32  instruction word.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address, bits [1:0] always 0.
- iload  in  32  memory read data, valid when iwait=0.
- iwait  in  1  memory busy; 0 means iload valid and request complete.

Behaviour:
- Address split:
  - index = imemaddr[IDX_W+1:2].
  - tag = imemaddr[31:IDX_W+2].
- Per-frame storage: valid bit, TAG_W tag, 32-bit data. All registered.
- Reset (nRST=0 at a clock edge):
  - All valid bits cleared; tag/data contents don't-care.
  - State returns to IDLE; miss address register cleared to 0.
  - Outputs while in reset state: ihit=0, imemload=0, iREN=0, iaddr=0.
- FSM states IDLE and MISS.
- IDLE:
  - hit = imemREN & valid[index] & (tag[index]==tag). Combinational.
  - ihit=hit; imemload = data[index] when hit, else 0; iREN=0; iaddr=0.
  - On imemREN & !hit: latch {imemaddr[31:2],2'b00} into miss_addr and go to MISS.
  - imemREN=0: stay IDLE with ihit=0, regardless of tag state.
- MISS:
  - iREN=1, iaddr=miss_addr, ihit=0, imemload=0.
  - iwait=1: stay MISS.
  - iwait=0: write iload into the frame at miss_addr's index, set the tag from miss_addr, set valid=1, go to IDLE.
- Miss latency:
  - Request seen in cycle 0 → iREN high from cycle 1.
  - Fill at the first edge with iwait=0 → ihit in the following cycle, if the address still matches.
  - Penalty = 2 + number of iwait=1 cycles.
- Fill target is always miss_addr, never the live imemaddr:
  - imemaddr changes or imemREN drops during MISS (branch/squash): the fill still completes to the latched address. No abort.
  - On return to IDLE the live request is re-evaluated and may start a new miss.
- Conflict: a fill overwrites the frame unconditionally (no write-back; read-only).
- Same-frame refill: the new tag and data replace the old; no stale hit in the cycle after the fill.
- Reset while in MISS: iREN drops the cycle after the reset edge; the partial fill is discarded; the valid bit is not set.
- No writes from the datapath. Self-modifying code is unsupported; a coherence invalidate port is out of scope.
- Width rules: the tag compare is exactly TAG_W bits; imemaddr[1:0] never affects hit, index or iaddr.

Test Plan:
- Cold miss: reset, imemREN=1, imemaddr=0x0000_0004, memory returns 0x2001_0005 after 3 iwait cycles.
  → iREN=1/iaddr=0x4 from cycle 1 to cycle 4; ihit=1 with imemload=0x2001_0005 in cycle 5.
- Hit after fill: re-request 0x0000_0004, and 0x0000_0007 (bits [1:0] ignored).
  → ihit=1 same cycle, iREN stays 0.
- Conflict (SETS=16): fill 0x0000_0000 with 0xAAAA_AAAA, then fill 0x0000_0040 with 0xBBBB_BBBB.
  → 0x40 then hits 0xBBBB_BBBB; 0x0 misses again (iREN=1, iaddr=0x0).
- Redirect mid-miss: miss on 0x100, change imemaddr to 0x200 while iwait=1.
  → iaddr held at 0x100 until iwait=0; frame for 0x100 valid afterwards; a new miss to 0x200 starts the next cycle.
- imemREN=0 against a valid frame holding 0x4.
  → ihit=0, imemload=0, iREN=0.
- Reset mid-miss: nRST=0 while in MISS on 0x8.
  → iREN=0 after the reset edge; a request to 0x8 after reset misses again.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with a one-word-per-miss fill FSM.
// Sits between the datapath icache port and the memory controller instruction channel.
module icache_dm #(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait
);

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SETS-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [TAG_W-1:0]  tag_d  [SETS];
    logic [31:0]       data_q [SETS];
    logic [31:0]       data_d [SETS];
    logic [29:0]       miss_word_q, miss_word_d;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              hit;
    logic              unused_byte_offset;

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[31:IDX_W+2];
    // The miss register holds a word address, so the fill index/tag come from its low/high bits.
    assign fill_idx = miss_word_q[IDX_W-1:0];
    assign fill_tag = miss_word_q[29:IDX_W];
    assign hit      = imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);

    assign unused_byte_offset = ^imemaddr[1:0];

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        miss_word_d = miss_word_q;
        ihit        = 1'b0;
        imemload    = '0;
        iREN        = 1'b0;
        iaddr       = '0;

        case (state_q)
            IDLE: begin
                ihit = hit;
                if (hit) begin
                    imemload = data_q[req_idx];
                end
                if (imemREN && !hit) begin
                    miss_word_d = imemaddr[31:2];
                    state_d     = MISS;
                end
            end
            MISS: begin
                // The fill always targets the latched address; a redirected or dropped
                // request is re-evaluated only after returning to IDLE.
                iREN  = 1'b1;
                iaddr = {miss_word_q, 2'b00};
                if (!iwait) begin
                    valid_d[fill_idx] = 1'b1;
                    tag_d[fill_idx]   = fill_tag;
                    data_d[fill_idx]  = iload;
                    state_d           = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_word_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            miss_word_q <= miss_word_d;
        end
    end

    // Tag and data arrays need no reset: valid bits gate every hit.
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed scenarios plus a randomized run against a
// set-of-resident-words reference model and a randomized memory responder.
module tb_icache_dm;

    localparam int SETS = 16;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        imem_ren = 1'b0;
    logic [31:0] imem_addr = '0;
    logic        ihit;
    logic [31:0] imem_load;
    logic        i_ren;
    logic [31:0] i_addr;
    logic [31:0] i_load = '0;
    logic        i_wait = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int wait_cfg = 0;
    int resp_cnt = 0;
    bit resp_busy = 1'b0;

    logic [31:0] mem [bit [29:0]];
    logic [31:0] exp_q [$];
    bit          model_valid [SETS];
    logic [29:0] model_word  [SETS];

    icache_dm #(.SETS(SETS)) dut (
        .CLK      (clk),
        .nRST     (n_rst),
        .imemREN  (imem_ren),
        .imemaddr (imem_addr),
        .ihit     (ihit),
        .imemload (imem_load),
        .iREN     (i_ren),
        .iaddr    (i_addr),
        .iload    (i_load),
        .iwait    (i_wait)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_get(input logic [29:0] w);
        if (!mem.exists(w)) mem[w] = $urandom;
        return mem[w];
    endfunction

    // Responder: wait_cfg iwait=1 cycles per request (random 0..4 when negative).
    always @(posedge clk) begin
        #1;
        if (i_ren === 1'b1) begin
            if (!resp_busy) begin
                resp_busy = 1'b1;
                resp_cnt  = (wait_cfg < 0) ? $urandom_range(0, 4) : wait_cfg;
            end
            if (resp_cnt > 0) begin
                i_wait = 1'b1;
                i_load = $urandom;
                resp_cnt--;
            end else begin
                i_wait    = 1'b0;
                i_load    = mem_get(i_addr[31:2]);
                resp_busy = 1'b0;
            end
        end else begin
            i_wait    = 1'b1;
            i_load    = $urandom;
            resp_busy = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    // A set holds at most one word; word w lives in set (w mod SETS).
    function automatic bit model_hit(input logic [29:0] w);
        int s;
        s = int'(w) % SETS;
        return model_valid[s] && (model_word[s] == w);
    endfunction

    // Observation vector: {ihit, iREN, iaddr, imemload}.
    function automatic logic [65:0] outs(input logic h, input logic r,
                                         input logic [31:0] a, input logic [31:0] d);
        return {h, r, a, d};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic ren, input logic [31:0] a);
        imem_ren  = ren;
        imem_addr = a;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        drive(1'b0, 32'h0);
        repeat (2) step();
        n_rst = 1'b1;
        for (int s = 0; s < SETS; s++) model_valid[s] = 1'b0;
        exp_q.delete();
    endtask

    task automatic fill(input logic [31:0] a, output bit ok);
        ok = 1'b0;
        step();
        drive(1'b1, a);
        for (int c = 0; c < 16; c++) begin
            sample();
            if (ihit === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 16; c++) begin
            step();
            sample();
            if (i_ren === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_rst = 1'b0;
        drive(1'b1, 32'h4);
        step();
        step();
        sample();
        n_checks++;
        if (outs(ihit, i_ren, i_addr, imem_load) !== outs(1'b0, 1'b0, 32'h0, 32'h0)) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h want %h", outs(ihit, i_ren, i_addr, imem_load),
                     outs(1'b0, 1'b0, 32'h0, 32'h0));
        end
    endtask

    task automatic test_cold_miss();
        wait_cfg = 3;
        mem[30'h1] = 32'h2001_0005;
        do_reset();
        drive(1'b1, 32'h4);
        sample();
        n_checks++;
        if (outs(ihit, i_ren, i_addr, imem_load) !== outs(1'b0, 1'b0, 32'h0, 32'h0)) begin
            n_errors++;
            $display("FAIL cold_c0: got %h want %h", outs(ihit, i_ren, i_addr, imem_load),
                     outs(1'b0, 1'b0, 32'h0, 32'h0));
        end
        for (int c = 1; c <= 4; c++) begin
            step();
            sample();
            n_checks++;
            if (outs(ihit, i_ren, i_addr, imem_load) !== outs(1'b0, 1'b1, 32'h4, 32'h0)) begin
                n_errors++;
                $display("FAIL cold_miss_c%0d: got %h want %h", c,
                         outs(ihit, i_ren, i_addr, imem_load), outs(1'b0, 1'b1, 32'h4, 32'h0));
            end
        end
        step();
        sample();
        n_checks++;
        if (outs(ihit, i_ren, i_addr, imem_load) !== outs(1'b1, 1'b0, 32'h0, 32'h2001_0005)) begin
            n_errors++;
            $display("FAIL cold_hit_c5: got %h want %h", outs(ihit, i_ren, i_addr, imem_load),
                     outs(1'b1, 1'b0, 32'h0, 32'h2001_0005));
        end
    endtask

    task automatic test_hit_after_fill();
        logic [31:0] addrs [2];
        addrs[0] = 32'h0000_0004;
        addrs[1] = 32'h0000_0007;
        for (int i = 0; i < 2; i++) begin
            step();
            drive(1'b1, addrs[i]);
            sample();
            n_checks++;
            if (outs(ihit, i_ren, i_addr, imem_load) !== outs(1'b1, 1'b0, 32'h0, 32'h2001_0005)) begin
                n_errors++;
                $display("FAIL hit_after_fill addr=%h: got %h want %h", addrs[i],
                         outs(ihit, i_ren, i_addr, imem_load), outs(1'b1, 1'b0, 32'h0, 32'h2001_0005));
            end
        end
    endtask

    task automatic test_ren_low();
        step();
        drive(1'b0, 32'h4);
        for (int c = 0; c < 2; c++) begin
            if (c > 0) step();
            sample();
            n_checks++;
            if (outs(ihit, i_ren, i_addr, imem_load) !== outs(1'b0, 1'b0, 32'h0, 32'h0)) begin
                n_errors++;
                $display("FAIL ren_low_c%0d: got %h want %h", c,
                         outs(ihit, i_ren, i_addr, imem_load), outs(1'b0, 1'b0, 32'h0, 32'h0));
            end
        end
    endtask

    task automatic test_conflict();
        bit ok;
        wait_cfg   = -1;
        mem[30'h0]  = 32'hAAAA_AAAA;
        mem[30'h10] = 32'hBBBB_BBBB;
        fill(32'h0, ok);
        n_checks++;
        if ({ok, imem_load} !== {1'b1, 32'hAAAA_AAAA}) begin
            n_errors++;
            $display("FAIL conflict_fill_0: got ok=%b load=%h want ok=1 load=aaaaaaaa", ok, imem_load);
        end
        fill(32'h40, ok);
        n_checks++;
        if ({ok, imem_load} !== {1'b1, 32'hBBBB_BBBB}) begin
            n_errors++;
            $display("FAIL conflict_fill_40: got ok=%b load=%h want ok=1 load=bbbbbbbb", ok, imem_load);
        end
        step();
        drive(1'b1, 32'h40);
        sample();
        n_checks++;
        if (outs(ihit, i_ren, i_addr, imem_load) !== outs(1'b1, 1'b0, 32'h0, 32'hBBBB_BBBB)) begin
            n_errors++;
            $display("FAIL conflict_hit_40: got %h want %h", outs(ihit, i_ren, i_addr, imem_load),
                     outs(1'b1, 1'b0, 32'h0, 32'hBBBB_BBBB));
        end
        step();
        drive(1'b1, 32'h0);
        sample();
        n_checks++;
        if (outs(ihit, i_ren, i_addr, imem_load) !== outs(1'b0, 1'b0, 32'h0, 32'h0)) begin
            n_errors++;
            $display("FAIL conflict_evicted_0: got %h want %h", outs(ihit, i_ren, i_addr, imem_load),
                     outs(1'b0, 1'b0, 32'h0, 32'h0));
        end
        step();
        sample();
        n_checks++;
        if (outs(ihit, i_ren, i_addr, imem_load) !== outs(1'b0, 1'b1, 32'h0, 32'h0)) begin
            n_errors++;
            $display("FAIL conflict_refetch_0: got %h want %h", outs(ihit, i_ren, i_addr, imem_load),
                     outs(1'b0, 1'b1, 32'h0, 32'h0));
        end
        fill(32'h0, ok);
        n_checks++;
        if ({ok, imem_load} !== {1'b1, 32'hAAAA_AAAA}) begin
            n_errors++;
            $display("FAIL conflict_refill_0: got ok=%b load=%h want ok=1 load=aaaaaaaa", ok, imem_load);
        end
    endtask

    task automatic test_redirect();
        bit          ok;
        logic [31:0] v104;
        wait_cfg = 3;
        step();
        drive(1'b1, 32'h100);
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 2) drive(1'b1, 32'h200);
            sample();
            n_checks++;
            if (outs(ihit, i_ren, i_addr, imem_load) !== outs(1'b0, 1'b1, 32'h100, 32'h0)) begin
                n_errors++;
                $display("FAIL redirect_hold_c%0d: got %h want %h", c,
                         outs(ihit, i_ren, i_addr, imem_load), outs(1'b0, 1'b1, 32'h100, 32'h0));
            end
        end
        step();
        sample();
        n_checks++;
        if (outs(ihit, i_ren, i_addr, imem_load) !== outs(1'b0, 1'b0, 32'h0, 32'h0)) begin
            n_errors++;
            $display("FAIL redirect_return: got %h want %h", outs(ihit, i_ren, i_addr, imem_load),
                     outs(1'b0, 1'b0, 32'h0, 32'h0));
        end
        step();
        sample();
        n_checks++;
        if (outs(ihit, i_ren, i_addr, imem_load) !== outs(1'b0, 1'b1, 32'h200, 32'h0)) begin
            n_errors++;
            $display("FAIL redirect_new_miss: got %h want %h", outs(ihit, i_ren, i_addr, imem_load),
                     outs(1'b0, 1'b1, 32'h200, 32'h0));
        end
        drive(1'b0, 32'h200);
        wait_idle(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_errors++;
            $display("FAIL redirect_drain: got ok=%b want ok=1", ok);
        end
        // Squash: request dropped mid-miss, fill must still land.
        wait_cfg = 2;
        v104 = mem_get(30'h41);
        step();
        drive(1'b1, 32'h104);
        for (int c = 1; c <= 3; c++) begin
            step();
            drive(1'b0, 32'h104);
            sample();
            n_checks++;
            if (outs(ihit, i_ren, i_addr, imem_load) !== outs(1'b0, 1'b1, 32'h104, 32'h0)) begin
                n_errors++;
                $display("FAIL squash_hold_c%0d: got %h want %h", c,
                         outs(ihit, i_ren, i_addr, imem_load), outs(1'b0, 1'b1, 32'h104, 32'h0));
            end
        end
        step();
        drive(1'b1, 32'h104);
        sample();
        n_checks++;
        if (outs(ihit, i_ren, i_addr, imem_load) !== outs(1'b1, 1'b0, 32'h0, v104)) begin
            n_errors++;
            $display("FAIL squash_fill_kept: got %h want %h", outs(ihit, i_ren, i_addr, imem_load),
                     outs(1'b1, 1'b0, 32'h0, v104));
        end
    endtask

    task automatic test_reset_mid_miss();
        bit          ok;
        logic [31:0] v8;
        wait_cfg = 1;
        v8 = mem_get(30'h2);
        step();
        drive(1'b1, 32'h8);
        step();
        sample();
        n_checks++;
        if (outs(ihit, i_ren, i_addr, imem_load) !== outs(1'b0, 1'b1, 32'h8, 32'h0)) begin
            n_errors++;
            $display("FAIL rst_miss_active: got %h want %h", outs(ihit, i_ren, i_addr, imem_load),
                     outs(1'b0, 1'b1, 32'h8, 32'h0));
        end
        // Reset lands on the same edge the responder completes the fill.
        step();
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        drive(1'b1, 32'h8);
        sample();
        n_checks++;
        if (outs(ihit, i_ren, i_addr, imem_load) !== outs(1'b0, 1'b0, 32'h0, 32'h0)) begin
            n_errors++;
            $display("FAIL rst_miss_dropped: got %h want %h", outs(ihit, i_ren, i_addr, imem_load),
                     outs(1'b0, 1'b0, 32'h0, 32'h0));
        end
        step();
        sample();
        n_checks++;
        if (outs(ihit, i_ren, i_addr, imem_load) !== outs(1'b0, 1'b1, 32'h8, 32'h0)) begin
            n_errors++;
            $display("FAIL rst_refetch: got %h want %h", outs(ihit, i_ren, i_addr, imem_load),
                     outs(1'b0, 1'b1, 32'h8, 32'h0));
        end
        fill(32'h8, ok);
        n_checks++;
        if ({ok, imem_load} !== {1'b1, v8}) begin
            n_errors++;
            $display("FAIL rst_refill: got ok=%b load=%h want ok=1 load=%h", ok, imem_load, v8);
        end
    endtask

    task automatic test_random();
        logic [25:0] hi_pool [4];
        logic [65:0] exp_v;
        logic [31:0] a;
        logic [29:0] w;
        logic        ren;
        logic        h;
        logic        last_wait;
        bit          in_miss;
        int          s;
        for (int i = 0; i < 4; i++) hi_pool[i] = 26'($urandom);
        hi_pool[0] = '0;
        wait_cfg  = -1;
        do_reset();
        in_miss   = 1'b0;
        last_wait = 1'b1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc > 0) step();
            if (in_miss && last_wait == 1'b0) begin
                w = exp_q[0][31:2];
                void'(exp_q.pop_front());
                s = int'(w) % SETS;
                model_valid[s] = 1'b1;
                model_word[s]  = w;
                in_miss = 1'b0;
            end
            ren = ($urandom_range(0, 9) != 0);
            a   = {hi_pool[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            drive(ren, a);
            sample();
            if (in_miss) begin
                exp_v     = outs(1'b0, 1'b1, exp_q[0], 32'h0);
                last_wait = i_wait;
            end else begin
                w     = a[31:2];
                h     = ren && model_hit(w);
                exp_v = outs(h, 1'b0, 32'h0, h ? mem_get(w) : 32'h0);
                if (ren && !h) begin
                    exp_q.push_back({w, 2'b00});
                    in_miss   = 1'b1;
                    last_wait = 1'b1;
                end
            end
            n_checks++;
            if (outs(ihit, i_ren, i_addr, imem_load) !== exp_v) begin
                n_errors++;
                $display("FAIL random_c%0d addr=%h ren=%b: got %h want %h", cyc, a, ren,
                         outs(ihit, i_ren, i_addr, imem_load), exp_v);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_cold_miss();
        test_hit_after_fill();
        test_ren_low();
        test_conflict();
        test_redirect();
        test_reset_mid_miss();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
